// File: rtl/clock_pkg.sv
// Shared definitions for the clock function controllers: mode codes, mode count
// and a counter-width helper.
package clock_pkg;

  localparam int NUM_MODES = 4;

  localparam logic [1:0] MODE_CLOCK     = 2'd0;
  localparam logic [1:0] MODE_ALARM     = 2'd1;
  localparam logic [1:0] MODE_TIMER     = 2'd2;
  localparam logic [1:0] MODE_STOPWATCH = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ms_interval_counter.sv
// Counts enabled ms pulses and flags the pulse that completes LIMIT of them.
// Down-counter: 0 means "not started", so a cleared counter restarts a full interval.
module ms_interval_counter
  import clock_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic clr,
  input  logic en,
  input  logic i_ms_pulse,
  output logic done
);

  localparam int W = clog2(LIMIT + 1);

  logic [W-1:0] remaining;
  logic         step;
  logic         terminal;

  assign step     = en & i_ms_pulse & ~clr;
  assign terminal = (remaining == '0) ? (LIMIT == 1) : (remaining == W'(1));
  assign done     = step & terminal;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      remaining <= '0;
    end else if (clr || done) begin
      remaining <= '0;
    end else if (step) begin
      remaining <= (remaining == '0) ? W'(LIMIT - 1) : remaining - W'(1);
    end
  end

endmodule

// File: rtl/clock_mode_scheduler.sv
// Time-shares the buttons and display among clock/alarm/timer/stopwatch, drives
// the setting blink; auto-return to clock is built when MODE_SCHED_AUTORETURN_EN is defined.
//
// mode       | meaning
// CLOCK  (0) | time of day shown, reset mode, auto-return target
// ALARM  (1) | alarm controller owns buttons and display
// TIMER  (2) | timer controller; forced here when the timer finishes
// STOPWATCH(3)| stopwatch controller
module clock_mode_scheduler
  import clock_pkg::*;
#(
  parameter int IDLE_MS       = 30000,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_ms_pulse,
  input  logic                 i_mode,
  input  logic                 i_set,
  input  logic                 i_up,
  input  logic                 i_down,
  input  logic                 i_left,
  input  logic                 i_right,
  input  logic [NUM_MODES-1:0] i_setting,
  input  logic                 i_timer_finish,
  output logic [1:0]           o_mode,
  output logic [NUM_MODES-1:0] o_set,
  output logic [NUM_MODES-1:0] o_up,
  output logic [NUM_MODES-1:0] o_down,
  output logic [NUM_MODES-1:0] o_left,
  output logic [NUM_MODES-1:0] o_right,
  output logic                 o_blink,
  output logic                 o_idle_return
);

  if (IDLE_MS < 2) begin : g_bad_idle_ms
    $error("IDLE_MS must be at least 2");
  end
  if (BLINK_HALF_MS < 1) begin : g_bad_blink_half_ms
    $error("BLINK_HALF_MS must be at least 1");
  end

  logic [1:0]           r_mode;
  logic                 pending_finish;
  logic                 locked;
  logic                 take_finish;
  logic [1:0]           step_mode;
  logic [1:0]           next_mode;
  logic                 mode_change;
  logic                 blink_clr;
  logic                 blink_done;
  logic                 idle_done;
  logic [NUM_MODES-1:0] mode_sel;

  assign locked      = i_setting[r_mode];
  assign take_finish = (i_timer_finish | pending_finish) & ~locked;

  assign mode_sel = {{(NUM_MODES-1){1'b0}}, 1'b1} << r_mode;
  assign o_set    = {NUM_MODES{i_set}}   & mode_sel;
  assign o_up     = {NUM_MODES{i_up}}    & mode_sel;
  assign o_down   = {NUM_MODES{i_down}}  & mode_sel;
  assign o_left   = {NUM_MODES{i_left}}  & mode_sel;
  assign o_right  = {NUM_MODES{i_right}} & mode_sel;
  assign o_mode   = r_mode;

  always_comb begin
    step_mode = MODE_CLOCK;
    case (r_mode)
      MODE_CLOCK:     step_mode = MODE_ALARM;
      MODE_ALARM:     step_mode = MODE_TIMER;
      MODE_TIMER:     step_mode = MODE_STOPWATCH;
      MODE_STOPWATCH: step_mode = MODE_CLOCK;
      default:        step_mode = MODE_CLOCK;
    endcase
  end

  always_comb begin
    next_mode = r_mode;
    if (take_finish) begin
      next_mode = MODE_TIMER;
    end else if (i_mode && !locked) begin
      next_mode = step_mode;
    end else if (idle_done) begin
      next_mode = MODE_CLOCK;
    end
  end

  assign mode_change = (next_mode != r_mode);

  // Adjusting the value keeps it visible and restarts the half-period.
  assign blink_clr = mode_change | ~locked | i_up | i_down;

  ms_interval_counter #(.LIMIT(BLINK_HALF_MS)) u_blink_counter (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .clr        (blink_clr),
    .en         (locked),
    .i_ms_pulse (i_ms_pulse),
    .done       (blink_done)
  );

`ifdef MODE_SCHED_AUTORETURN_EN
  logic any_button;
  assign any_button = i_mode | i_set | i_up | i_down | i_left | i_right;

  // The counter self-clears on its own timeout, so its clear omits that mode change.
  ms_interval_counter #(.LIMIT(IDLE_MS)) u_idle_counter (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .clr        (any_button | take_finish | locked),
    .en         (r_mode != MODE_CLOCK),
    .i_ms_pulse (i_ms_pulse),
    .done       (idle_done)
  );
`else
  assign idle_done = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_mode         <= MODE_CLOCK;
      pending_finish <= 1'b0;
      o_blink        <= 1'b1;
      o_idle_return  <= 1'b0;
    end else begin
      r_mode        <= next_mode;
      o_idle_return <= idle_done & ~take_finish;

      if (take_finish) begin
        pending_finish <= 1'b0;
      end else if (i_timer_finish && locked) begin
        pending_finish <= 1'b1;
      end

      if (blink_clr) begin
        o_blink <= 1'b1;
      end else if (blink_done) begin
        o_blink <= ~o_blink;
      end
    end
  end

endmodule

// File: tb/tb_clock_mode_scheduler.sv
// Directed bench for clock_mode_scheduler with IDLE_MS=20, BLINK_HALF_MS=4;
// idle-return checks follow MODE_SCHED_AUTORETURN_EN.
module tb_clock_mode_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_ms_pulse;
  logic       i_mode;
  logic       i_set, i_up, i_down, i_left, i_right;
  logic [3:0] i_setting;
  logic       i_timer_finish;
  logic [1:0] o_mode;
  logic [3:0] o_set, o_up, o_down, o_left, o_right;
  logic       o_blink;
  logic       o_idle_return;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  clock_mode_scheduler #(.IDLE_MS(20), .BLINK_HALF_MS(4)) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_ms_pulse     (i_ms_pulse),
    .i_mode         (i_mode),
    .i_set          (i_set),
    .i_up           (i_up),
    .i_down         (i_down),
    .i_left         (i_left),
    .i_right        (i_right),
    .i_setting      (i_setting),
    .i_timer_finish (i_timer_finish),
    .o_mode         (o_mode),
    .o_set          (o_set),
    .o_up           (o_up),
    .o_down         (o_down),
    .o_left         (o_left),
    .o_right        (o_right),
    .o_blink        (o_blink),
    .o_idle_return  (o_idle_return)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ms(input int n);
    for (int k = 0; k < n; k++) begin
      i_ms_pulse = 1'b1;
      tick();
      i_ms_pulse = 1'b0;
      tick();
    end
  endtask

  task automatic press_mode();
    i_mode = 1'b1;
    tick();
    i_mode = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b1;
    i_ms_pulse = 1'b0;
    i_mode = 1'b0;
    i_set = 1'b0; i_up = 1'b0; i_down = 1'b0; i_left = 1'b0; i_right = 1'b0;
    i_setting = 4'b0000;
    i_timer_finish = 1'b0;
    #2 i_rstn = 1'b0;
    tick();
    tick();
    check("reset_mode", 4'(o_mode), 4'd0);
    check("reset_blink", 4'(o_blink), 4'd1);
    check("reset_idle_return", 4'(o_idle_return), 4'd0);
    check("reset_up_routing", o_up, 4'b0000);
    i_rstn = 1'b1;
    tick();

    // mode cycling; i_up in the same cycle as i_mode goes to the old mode
    for (int k = 0; k < 4; k++) begin
      i_up = 1'b1;
      i_mode = 1'b1;
      #1;
      check("cycle_up_route", o_up, 4'(1 << k));
      check("cycle_down_quiet", o_down, 4'b0000);
      tick();
      i_up = 1'b0;
      i_mode = 1'b0;
      check("cycle_mode", 4'(o_mode), 4'((k + 1) % 4));
      check("cycle_blink", 4'(o_blink), 4'd1);
      tick();
    end

    // locked in ALARM: mode button ignored, blink toggles every 4 ms
    press_mode();
    check("enter_alarm", 4'(o_mode), 4'd1);
    i_setting = 4'b0010;
    tick();
    press_mode();
    check("locked_mode_ignored", 4'(o_mode), 4'd1);
    ms(3);
    check("blink_before_half", 4'(o_blink), 4'd1);
    ms(1);
    check("blink_first_toggle", 4'(o_blink), 4'd0);
    ms(2);
    i_up = 1'b1;
    #1;
    check("locked_up_route", o_up, 4'b0010);
    tick();
    i_up = 1'b0;
    check("blink_forced_by_up", 4'(o_blink), 4'd1);
    ms(3);
    check("blink_restarted_hold", 4'(o_blink), 4'd1);
    ms(1);
    check("blink_restarted_toggle", 4'(o_blink), 4'd0);

    // timer finish from STOPWATCH, then deferred while locked in ALARM
    i_setting = 4'b0000;
    tick();
    check("unlock_blink", 4'(o_blink), 4'd1);
    press_mode();
    press_mode();
    check("enter_stopwatch", 4'(o_mode), 4'd3);
    i_timer_finish = 1'b1;
    tick();
    i_timer_finish = 1'b0;
    check("finish_switch", 4'(o_mode), 4'd2);
    press_mode();
    press_mode();
    press_mode();
    check("back_to_alarm", 4'(o_mode), 4'd1);
    i_setting = 4'b0010;
    tick();
    i_timer_finish = 1'b1;
    tick();
    i_timer_finish = 1'b0;
    check("finish_deferred", 4'(o_mode), 4'd1);
    tick();
    tick();
    i_setting = 4'b0000;
    #1;
    check("finish_still_deferred", 4'(o_mode), 4'd1);
    tick();
    check("pending_finish_switch", 4'(o_mode), 4'd2);

    // same-cycle mode button and finish in CLOCK: finish wins
    press_mode();
    press_mode();
    check("back_to_clock", 4'(o_mode), 4'd0);
    i_mode = 1'b1;
    i_timer_finish = 1'b1;
    tick();
    i_mode = 1'b0;
    i_timer_finish = 1'b0;
    check("finish_beats_mode", 4'(o_mode), 4'd2);

    // async reset while in TIMER with a pending finish and blink blanked
    i_setting = 4'b0100;
    tick();
    i_timer_finish = 1'b1;
    tick();
    i_timer_finish = 1'b0;
    ms(4);
    check("timer_locked_blink", 4'(o_blink), 4'd0);
    check("timer_locked_mode", 4'(o_mode), 4'd2);
    i_rstn = 1'b0;
    #1;
    check("async_reset_mode", 4'(o_mode), 4'd0);
    check("async_reset_blink", 4'(o_blink), 4'd1);
    i_setting = 4'b0000;
    tick();
    i_rstn = 1'b1;
    tick();
    tick();
    tick();
    check("no_spurious_finish", 4'(o_mode), 4'd0);

    // idle return
    press_mode();
    check("idle_enter_alarm", 4'(o_mode), 4'd1);
`ifdef MODE_SCHED_AUTORETURN_EN
    ms(19);
    check("idle_before_limit", 4'(o_mode), 4'd1);
    check("idle_no_pulse_early", 4'(o_idle_return), 4'd0);
    i_ms_pulse = 1'b1;
    tick();
    i_ms_pulse = 1'b0;
    check("idle_return_mode", 4'(o_mode), 4'd0);
    check("idle_return_pulse", 4'(o_idle_return), 4'd1);
    tick();
    check("idle_pulse_one_cycle", 4'(o_idle_return), 4'd0);
    press_mode();
    ms(14);
    i_ms_pulse = 1'b1;
    i_left = 1'b1;
    tick();
    i_ms_pulse = 1'b0;
    i_left = 1'b0;
    tick();
    ms(19);
    check("idle_left_restart", 4'(o_mode), 4'd1);
    i_ms_pulse = 1'b1;
    tick();
    i_ms_pulse = 1'b0;
    check("idle_return_at_35", 4'(o_mode), 4'd0);
    check("idle_return_pulse_35", 4'(o_idle_return), 4'd1);
    tick();
`else
    ms(100);
    check("no_idle_return_mode", 4'(o_mode), 4'd1);
    check("no_idle_return_pulse", 4'(o_idle_return), 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
